// File: rtl/lane_seed_gen.sv
// Sequential seed fan-out for parallel xorshift32 lanes: lane k receives T^(k*stride)(seed).
// Optional macro SEED_ZERO_GUARD_EN replaces an all-zero master seed with 32'h2545F491 at latch.
//
//  state | meaning
//  IDLE  | waiting for start; outputs quiet
//  EMIT  | presenting a lane seed on the output stream
//  STEP  | advancing x by stride xorshift steps toward the next lane
module lane_seed_gen #(
    parameter int NUM_LANES = 4,
    parameter int STRIDE_W  = 16,
    parameter int LANE_W    = ($clog2(NUM_LANES) > 0) ? $clog2(NUM_LANES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         seed_in,
    input  logic [STRIDE_W-1:0] stride_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_data,
    output logic [LANE_W-1:0]   out_lane,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    state_t                state, state_d;
    logic [31:0]           x, x_d;
    logic [STRIDE_W-1:0]   cnt, cnt_d;
    logic [STRIDE_W-1:0]   stride_q, stride_d;
    logic [LANE_W-1:0]     lane, lane_d;
    logic                  out_valid_d;
    logic [31:0]           out_data_d;
    logic [LANE_W-1:0]     out_lane_d;
    logic                  busy_d;
    logic                  done_d;
    logic [31:0]           seed_eff;
    logic [31:0]           x_next;

    function automatic logic [31:0] xs_step(input logic [31:0] v);
        logic [31:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

`ifdef SEED_ZERO_GUARD_EN
    // zero is a fixed point of the xorshift step, so it would yield all-zero lanes
    assign seed_eff = (seed_in == 32'h0) ? 32'h2545F491 : seed_in;
`else
    assign seed_eff = seed_in;
`endif

    assign x_next = xs_step(x);

    always_comb begin
        state_d     = state;
        x_d         = x;
        cnt_d       = cnt;
        stride_d    = stride_q;
        lane_d      = lane;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_lane_d  = out_lane;
        done_d      = 1'b0;

        case (state)
            IDLE: begin
                out_valid_d = 1'b0;
                if (start) begin
                    state_d     = EMIT;
                    x_d         = seed_eff;
                    stride_d    = stride_in;
                    lane_d      = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = seed_eff;
                    out_lane_d  = '0;
                end
            end
            EMIT: begin
                if (!out_valid) begin
                    // bubble after a zero-stride handshake: re-present x for the new lane
                    out_valid_d = 1'b1;
                    out_data_d  = x;
                    out_lane_d  = lane;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (lane == LAST_LANE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        lane_d     = lane + LANE_W'(1);
                        out_lane_d = lane + LANE_W'(1);
                        if (stride_q == '0) begin
                            state_d = EMIT;
                        end else begin
                            state_d = STEP;
                            cnt_d   = stride_q;
                        end
                    end
                end
            end
            STEP: begin
                out_valid_d = 1'b0;
                x_d         = x_next;
                cnt_d       = cnt - STRIDE_W'(1);
                // the final step is emitted in the same cycle it is taken
                if (cnt == STRIDE_W'(1)) begin
                    state_d     = EMIT;
                    out_valid_d = 1'b1;
                    out_data_d  = x_next;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            cnt       <= '0;
            stride_q  <= '0;
            lane      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            x         <= x_d;
            cnt       <= cnt_d;
            stride_q  <= stride_d;
            lane      <= lane_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_lane  <= out_lane_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_lane_seed_gen.sv
// Randomized bench for lane_seed_gen against a plain xorshift32 reference model.
// Define SEED_ZERO_GUARD_EN for both DUT and bench to exercise the zero-seed guard.
module tb_lane_seed_gen;

    localparam int NL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] seed_in;
    logic [15:0] stride_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_lane;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] obs [NL];

    always #5 clk = ~clk;

    lane_seed_gen #(.NUM_LANES(NL), .STRIDE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed_in   (seed_in),
        .stride_in (stride_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] t;
        t = v;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic logic [31:0] seed_eff(input logic [31:0] s);
`ifdef SEED_ZERO_GUARD_EN
        return (s == 32'h0) ? 32'h2545F491 : s;
`else
        return s;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 random ready, 1 always ready, 2 stall lane 1 for 5 cycles, 3 always ready + reset in STEP of lane 2
    task automatic do_req(input logic [31:0] seed, input logic [15:0] stride, input int mode);
        logic [31:0] exp_q [NL];
        logic [31:0] x;
        logic [31:0] held_d;
        logic [1:0]  held_l;
        logic        rdy;
        logic        prev_hold;
        logic        gap_pending;
        logic        finished;
        int k, gap, hold, budget, want_gap;

        x = seed_eff(seed);
        for (int i = 0; i < NL; i++) begin
            exp_q[i] = x;
            for (int s = 0; s < int'(stride); s++) x = xs(x);
        end
        want_gap = (stride == 16'd0) ? 2 : int'(stride) + 1;

        start     = 1'b1;
        seed_in   = seed;
        stride_in = stride;
        tick();
        start = 1'b0;
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("busy_on_start", 32'(busy), 32'd1);
        chk("done_low", 32'(done), 32'd0);

        k = 0; gap = 0; hold = 0; budget = 0;
        prev_hold = 1'b0; gap_pending = 1'b0; finished = 1'b0;
        held_d = '0; held_l = '0;
        while (!finished && budget < 2000) begin
            if (mode == 3 && k == 2 && gap == 2 && !out_valid) begin
                rst = 1'b1; out_ready = 1'b0; start = 1'b0;
                tick();
                rst = 1'b0;
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_data", out_data, 32'd0);
                chk("rst_lane", 32'(out_lane), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                return;
            end
            seed_in   = $urandom;
            stride_in = 16'($urandom);
            start     = ($urandom_range(0, 3) == 0);
            chk("busy_mid", 32'(busy), 32'd1);
            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, held_d);
                chk("hold_lane", 32'(out_lane), 32'(held_l));
            end
            prev_hold = 1'b0;
            if (out_valid) begin
                if (gap_pending) begin
                    chk("gap", 32'(gap), 32'(want_gap));
                    gap_pending = 1'b0;
                end
                case (mode)
                    0: rdy = 1'($urandom_range(0, 1));
                    2: begin
                        rdy = !(k == 1 && hold < 5);
                        if (!rdy) hold++;
                    end
                    default: rdy = 1'b1;
                endcase
                out_ready = rdy;
                if (rdy) begin
                    chk("lane_data", out_data, exp_q[k]);
                    chk("lane_idx", 32'(out_lane), 32'(k));
                    obs[k] = out_data;
                    k++;
                    gap = 0;
                    gap_pending = 1'b1;
                    if (k == NL) finished = 1'b1;
                end else begin
                    prev_hold = 1'b1;
                    held_d = out_data;
                    held_l = out_lane;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            gap++;
            budget++;
            tick();
        end
        start = 1'b0;
        chk("timeout", 32'(finished), 32'd1);
        if (mode == 2) chk("stall_cycles", 32'(hold), 32'd5);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("valid_after", 32'(out_valid), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_valid", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; seed_in = '0; stride_in = '0; out_ready = 1'b0;
        tick();
        tick();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", out_data, 32'd0);
        chk("reset_lane", 32'(out_lane), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        idle(1);

        do_req(32'd1, 16'd1, 1);
        chk("t1_lane0", obs[0], 32'h00000001);
        chk("t1_lane1", obs[1], 32'h00042021);
        chk("t1_lane2", obs[2], 32'h04080601);
        idle(2);

        do_req(32'd1, 16'd2, 1);
        chk("t2_lane1", obs[1], 32'h04080601);
        idle(1);

        do_req(32'hDEADBEEF, 16'd0, 1);
        for (int i = 0; i < NL; i++) chk("t3_lane", obs[i], 32'hDEADBEEF);

        // back-to-back: new start lands in the done cycle
        do_req(32'h12345678, 16'd3, 2);
        do_req(32'h0, 16'd2, 1);
`ifdef SEED_ZERO_GUARD_EN
        chk("t5_lane0", obs[0], 32'h2545F491);
`else
        for (int i = 0; i < NL; i++) chk("t5_lane", obs[i], 32'h0);
`endif
        idle(1);

        do_req(32'hCAFEF00D, 16'd3, 3);
        idle(2);
        do_req(32'h0BADC0DE, 16'd1, 1);
        chk("t6_lane0", obs[0], 32'h0BADC0DE);
        idle(1);

        for (int r = 0; r < 24; r++) begin
            do_req($urandom, 16'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
